// File: rtl/lbus_target_sm_if.sv
// Local-bus target interface: initiator-side transfer attributes, termination
// outputs and the request/acknowledge handshake to the peripheral backend.
//   slave  : the target state machine (decodes the transfer, drives termination)
//   master : the initiator plus backend side (starts transfers, answers requests)
interface lbus_target_sm_if;
  logic       TSn;
  logic       SEL;
  logic       RnW;
  logic [1:0] SIZ;
  logic [1:0] A;
  logic       PORT16;
  logic       PORTSIZE;
  logic       TERM_OE;
  logic       TACKn;
  logic       TEAn;
  logic       TBIn;
  logic       DEV_REQ;
  logic       DEV_WE;
  logic [3:0] DEV_BE;
  logic [1:0] DEV_BEAT;
  logic       DEV_ACK;
  logic       DEV_RETRY;
  logic       DEV_ERR;

  modport slave (
    input  TSn, SEL, RnW, SIZ, A, PORT16, DEV_ACK, DEV_RETRY, DEV_ERR,
    output PORTSIZE, TERM_OE, TACKn, TEAn, TBIn,
           DEV_REQ, DEV_WE, DEV_BE, DEV_BEAT
  );

  modport master (
    output TSn, SEL, RnW, SIZ, A, PORT16, DEV_ACK, DEV_RETRY, DEV_ERR,
    input  PORTSIZE, TERM_OE, TACKn, TEAn, TBIn,
           DEV_REQ, DEV_WE, DEV_BE, DEV_BEAT
  );
endinterface

// File: rtl/lbus_target_sm.sv
// Local-bus target cycle state machine. Decodes a transfer start, reports the
// port size, generates byte enables and line-burst beat numbers, handshakes
// with the backend and drives the {TACKn, TEAn, TBIn} termination.
//   TIMEOUT : backend response limit per beat in CLK40 cycles (1..255)
//   CLK40   : local bus clock, rising edge
//   RESETn  : asynchronous active-low reset
//   bus     : lbus_target_sm_if.slave (transfer attributes, termination,
//             backend request/response)
module lbus_target_sm #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic            CLK40,
  input  logic            RESETn,
  lbus_target_sm_if.slave bus
);

  typedef enum logic [1:0] {IDLE, REQ, TERM, RECOVER} state_t;

  localparam logic [7:0] LIMIT = 8'(TIMEOUT);

  state_t     state, state_nxt;
  logic [7:0] cnt;
  logic       first_q;   // first REQ cycle after the start: responses not sampled
  logic       we_q;
  logic [1:0] siz_q;
  logic       p16_q;
  logic [3:0] be_q;
  logic [1:0] beat_q;
  logic [1:0] term_q;    // {TACKn, TEAn} for the TERM cycle
  logic       tbi_q;
  logic       last_q;    // TERM ends the transfer (otherwise the burst continues)

  logic       start;
  logic [3:0] be_dec;
  logic       sample, timeout, hit, burst, final_beat;
  logic [1:0] code;

  assign start = !bus.TSn && bus.SEL;

  always_comb begin : be_decode
    be_dec = '0;
    if (!bus.PORT16) begin
      case (bus.SIZ)
        2'b01:   be_dec = 4'b1000 >> bus.A;
        2'b10:   be_dec = bus.A[1] ? 4'b0011 : 4'b1100;
        default: be_dec = '1;
      endcase
    end else begin
      case (bus.SIZ)
        2'b01:   be_dec = bus.A[0] ? 4'b0100 : 4'b1000;
        default: be_dec = 4'b1100;
      endcase
    end
  end

  always_comb begin : response
    sample  = (state == REQ) && !first_q;
    timeout = (state == REQ) && (cnt == LIMIT);
    hit     = (sample && (bus.DEV_ERR || bus.DEV_RETRY || bus.DEV_ACK)) || timeout;
    if (sample && bus.DEV_ERR)        code = 2'b10;
    else if (sample && bus.DEV_RETRY) code = 2'b00;
    else if (timeout)                 code = 2'b10;
    else                              code = 2'b01;
    burst      = (siz_q == 2'b11) && !p16_q;
    final_beat = !((code == 2'b01) && burst && (beat_q != 2'b11));
  end

  always_ff @(posedge CLK40 or negedge RESETn) begin : state_reg
    if (!RESETn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin : next_state
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = REQ;
      REQ:     if (hit) state_nxt = TERM;
      TERM:    state_nxt = last_q ? RECOVER : REQ;
      RECOVER: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK40 or negedge RESETn) begin : datapath
    if (!RESETn) begin
      cnt     <= '0;
      first_q <= 1'b0;
      we_q    <= 1'b0;
      siz_q   <= '0;
      p16_q   <= 1'b0;
      be_q    <= '0;
      beat_q  <= '0;
      term_q  <= '1;
      tbi_q   <= 1'b1;
      last_q  <= 1'b1;
    end else begin
      case (state)
        IDLE: if (start) begin
          we_q    <= !bus.RnW;
          siz_q   <= bus.SIZ;
          p16_q   <= bus.PORT16;
          be_q    <= be_dec;
          beat_q  <= '0;
          cnt     <= '0;
          first_q <= 1'b1;
        end
        REQ: begin
          cnt     <= cnt + 8'd1;
          first_q <= 1'b0;
          if (hit) begin
            term_q <= code;
            last_q <= final_beat;
            // A 16-bit port inhibits the line burst on its only acknowledge.
            tbi_q  <= !((code == 2'b01) && (siz_q == 2'b11) && p16_q);
          end
        end
        TERM: if (!last_q) begin
          beat_q <= beat_q + 2'd1;
          cnt    <= '0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin : outputs
    bus.PORTSIZE = bus.SEL && bus.PORT16;
    bus.TERM_OE  = (state != IDLE);
    bus.TACKn    = (state == TERM) ? term_q[1] : 1'b1;
    bus.TEAn     = (state == TERM) ? term_q[0] : 1'b1;
    bus.TBIn     = (state == TERM) ? tbi_q : 1'b1;
    // Request stays up through the TERM cycles between burst beats.
    bus.DEV_REQ  = (state == REQ) || ((state == TERM) && !last_q);
    bus.DEV_WE   = we_q;
    bus.DEV_BE   = be_q;
    bus.DEV_BEAT = beat_q;
  end

endmodule
